// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the two-channel DAC SPI scheduler.
package dac_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  localparam int FRAME_W      = 16;
  localparam int DATA_W       = 12;
  localparam int SHIFT_CYCLES = 32;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/dac_spi_shifter.sv
// Frame shift register and SCK generator: SCK = ICLK/2, data advances on SCK fall.
module dac_spi_shifter
  import dac_sched_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] data_i,
  input  logic               go_i,
  output logic               sck_o,
  output logic               sdi_o,
  output logic               done_o
);

  localparam int CW = $clog2(SHIFT_CYCLES + 1);

  logic [FRAME_W-1:0] sreg_q;
  logic               sck_q;
  logic [CW-1:0]      cnt_q;

  // cnt_q counts SCK half-periods; it parks at SHIFT_CYCLES until the next load.
  assign done_o = (cnt_q == CW'(SHIFT_CYCLES));
  assign sck_o  = sck_q;
  assign sdi_o  = sreg_q[FRAME_W-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
      sck_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
      sck_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (go_i && !done_o) begin
      sck_q <= ~sck_q;
      cnt_q <= cnt_q + CW'(1);
      if (sck_q) sreg_q <= {sreg_q[FRAME_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/dac_spi_sched.sv
// Round-robin two-channel scheduler driving a serial DAC (nCS/SCK/SDI).
// Optional nLDAC strobe generation enabled by DAC_SCHED_LDAC_EN.
module dac_spi_sched
  import dac_sched_pkg::*;
#(
  parameter int         DW         = 8,
  parameter logic [2:0] CMD        = 3'b111,
  parameter int         GAP_CYCLES = 2
) (
  input  logic          ICLK,
  input  logic          nRST,
  input  logic          REQ_A,
  input  logic          REQ_B,
  input  logic [DW-1:0] DAT_A,
  input  logic [DW-1:0] DAT_B,
  output logic          ACK_A,
  output logic          ACK_B,
  output logic          nCS,
  output logic          SCK,
  output logic          SDI,
  output logic          nLDAC,
  output logic          BUSY
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e             state_q, state_d;
  logic               ncs_q, ncs_d;
  logic               ack_a_q, ack_a_d;
  logic               ack_b_q, ack_b_d;
  logic               last_q, last_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               win, load, go, done;
  logic [DW-1:0]      dat_win;
  logic [DATA_W-1:0]  field;
  logic [FRAME_W-1:0] frame;

  // On a tie the channel not served last wins; otherwise the lone requester.
  assign win     = (REQ_A && REQ_B) ? ~last_q : REQ_B;
  assign dat_win = (win == CH_B) ? DAT_B : DAT_A;
  assign field   = DATA_W'(dat_win) << (DATA_W - DW);
  assign frame   = {win, CMD, field};
  assign go      = (state_q == S_SETUP) || (state_q == S_SHIFT);

  always_comb begin
    state_d = state_q;
    ncs_d   = ncs_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    last_d  = last_q;
    gap_d   = gap_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_A || REQ_B) begin
          load    = 1'b1;
          ack_a_d = (win == CH_A);
          ack_b_d = (win == CH_B);
          last_d  = win;
          ncs_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_SHIFT;
      S_SHIFT: if (done) state_d = S_HOLD;
      S_HOLD: begin
        ncs_d   = 1'b1;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ICLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ncs_q   <= 1'b1;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      last_q  <= CH_B;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ncs_q   <= ncs_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  dac_spi_shifter u_shifter (
    .clk_i  (ICLK),
    .rst_ni (nRST),
    .load_i (load),
    .data_i (frame),
    .go_i   (go),
    .sck_o  (SCK),
    .sdi_o  (SDI),
    .done_o (done)
  );

`ifdef DAC_SCHED_LDAC_EN
  logic nldac_q;

  // Low for the first two GAP cycles, registered so the pin is glitch-free.
  always_ff @(posedge ICLK or negedge nRST) begin
    if (!nRST) nldac_q <= 1'b1;
    else       nldac_q <= !((state_d == S_GAP) && (gap_d < GW'(2)));
  end

  assign nLDAC = nldac_q;
`else
  assign nLDAC = 1'b0;
`endif

  assign nCS   = ncs_q;
  assign ACK_A = ack_a_q;
  assign ACK_B = ack_b_q;
  assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dac_spi_sched.sv
// Directed bench for dac_spi_sched: scoreboard of expected frames checked by a pin monitor.
module tb_dac_spi_sched;

`ifdef DAC_SCHED_LDAC_EN
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam logic LDAC_IDLE = 1'b0;
`endif
  localparam logic LDAC_PULSE = 1'b0;

  logic       ICLK = 1'b0;
  logic       nRST = 1'b0;
  logic       REQ_A = 1'b0, REQ_B = 1'b0;
  logic [7:0] DAT_A = '0, DAT_B = '0;
  logic       ACK_A, ACK_B, nCS, SCK, SDI, nLDAC, BUSY;

  logic        REQ_A12 = 1'b0, REQ_B12 = 1'b0;
  logic [11:0] DAT_A12 = '0, DAT_B12 = '0;
  logic        ACK_A12, ACK_B12, nCS12, SCK12, SDI12, nLDAC12, BUSY12;

  dac_spi_sched dut (
    .ICLK(ICLK), .nRST(nRST), .REQ_A(REQ_A), .REQ_B(REQ_B), .DAT_A(DAT_A), .DAT_B(DAT_B),
    .ACK_A(ACK_A), .ACK_B(ACK_B), .nCS(nCS), .SCK(SCK), .SDI(SDI), .nLDAC(nLDAC), .BUSY(BUSY)
  );

  dac_spi_sched #(.DW(12)) dut12 (
    .ICLK(ICLK), .nRST(nRST), .REQ_A(REQ_A12), .REQ_B(REQ_B12), .DAT_A(DAT_A12), .DAT_B(DAT_B12),
    .ACK_A(ACK_A12), .ACK_B(ACK_B12), .nCS(nCS12), .SCK(SCK12), .SDI(SDI12), .nLDAC(nLDAC12),
    .BUSY(BUSY12)
  );

  always #5 ICLK = ~ICLK;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge ICLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pin monitor for the DW=8 instance
  logic [15:0] exp_q[$];
  logic [15:0] exp12[$];
  int          starts[$];
  logic [15:0] mbits;
  int          nbits = 0, ncs_len = 0, post_k = 0, ack_a_cnt = 0, ack_b_cnt = 0;
  bit          in_frame = 0;
  logic        sck_prev = 1'b0;

  always @(negedge ICLK) begin
    if (!nRST) begin
      in_frame = 0;
      post_k   = 0;
      sck_prev = 1'b0;
    end else begin
      if (ACK_A) ack_a_cnt++;
      if (ACK_B) ack_b_cnt++;
      if (!nCS) begin
        if (!in_frame) begin
          in_frame = 1;
          nbits    = 0;
          ncs_len  = 0;
          mbits    = '0;
          starts.push_back(cyc);
        end
        ncs_len++;
        if (SCK && !sck_prev) begin
          mbits = {mbits[14:0], SDI};
          nbits++;
        end
      end else if (in_frame) begin
        in_frame = 0;
        chk("frame_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("frame_bits", 32'(mbits), 32'(exp_q.pop_front()));
        chk("ncs_low_len", ncs_len, 34);
        chk("sck_rises", nbits, 16);
        post_k = 1;
      end
      if (post_k > 0) begin
        chk("nldac_after_frame", 32'(nLDAC), 32'((post_k < 3) ? LDAC_PULSE : LDAC_IDLE));
        post_k = (post_k == 3) ? 0 : post_k + 1;
      end
      sck_prev = SCK;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ICLK);
  endtask

  task automatic wait_ack(input string tag);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge ICLK);
      if (ACK_A || ACK_B) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 80; i++) begin
      @(negedge ICLK);
      if (!BUSY) break;
    end
    chk(tag, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int          a0, b0, len;
    logic [15:0] bits;
    logic        sp;
    bit          ok;

    // Reset values
    tick(3);
    chk("rst_ncs", 32'(nCS), 32'd1);
    chk("rst_sck", 32'(SCK), 32'd0);
    chk("rst_sdi", 32'(SDI), 32'd0);
    chk("rst_ack", 32'({ACK_A, ACK_B}), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_nldac", 32'(nLDAC), 32'(LDAC_IDLE));
    nRST = 1'b1;
    tick(2);

    // Channel B alone
    DAT_B = 8'h3C; REQ_B = 1'b1; exp_q.push_back(16'hF3C0);
    wait_ack("b_ack_timeout");
    chk("b_ack_who", 32'({ACK_A, ACK_B}), 32'b01);
    chk("b_ack_ncs_low", 32'(nCS), 32'd0);
    REQ_B = 1'b0;
    tick(1);
    chk("b_ack_pulse_width", 32'(ACK_B), 32'd0);
    wait_idle("b_idle_timeout");
    chk("b_ack_a_cnt", ack_a_cnt, 0);
    chk("b_ack_b_cnt", ack_b_cnt, 1);

    // Channel A alone
    DAT_A = 8'hA5; REQ_A = 1'b1; exp_q.push_back(16'h7A50);
    wait_ack("a_ack_timeout");
    chk("a_ack_who", 32'({ACK_A, ACK_B}), 32'b10);
    REQ_A = 1'b0;
    wait_idle("a_idle_timeout");
    chk("a_ack_a_cnt", ack_a_cnt, 1);

    // Reset returns the last-served pointer to B, so A wins the first tie
    tick(1); nRST = 1'b0; tick(2); nRST = 1'b1; tick(1);
    starts.delete();
    a0 = ack_a_cnt; b0 = ack_b_cnt;
    DAT_A = 8'h11; DAT_B = 8'h22;
    exp_q.push_back(16'h7110); exp_q.push_back(16'hF220); exp_q.push_back(16'h7110);
    REQ_A = 1'b1; REQ_B = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_ack("tie_ack_timeout");
      chk("tie_winner", 32'({ACK_A, ACK_B}), (f == 1) ? 32'b01 : 32'b10);
      if (f == 2) begin REQ_A = 1'b0; REQ_B = 1'b0; end
    end
    wait_idle("tie_idle_timeout");
    chk("tie_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("tie_period_1", starts[1] - starts[0], 37);
      chk("tie_period_2", starts[2] - starts[1], 37);
    end
    chk("tie_ack_a", ack_a_cnt - a0, 2);
    chk("tie_ack_b", ack_b_cnt - b0, 1);

    // Reset mid-SHIFT abandons the frame; a pending B starts fresh after release
    DAT_A = 8'h5A; REQ_A = 1'b1;
    wait_ack("mid_ack_timeout");
    REQ_A = 1'b0;
    tick(10);
    a0 = ack_a_cnt; b0 = ack_b_cnt;
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_ncs", 32'(nCS), 32'd1);
    chk("mid_rst_sck", 32'(SCK), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    DAT_B = 8'hC3; REQ_B = 1'b1; exp_q.push_back(16'hFC30);
    tick(2);
    nRST = 1'b1;
    wait_ack("post_rst_ack_timeout");
    chk("post_rst_ack_who", 32'({ACK_A, ACK_B}), 32'b01);
    REQ_B = 1'b0;

    // REQ_A withdrawn before it can be served
    tick(3); REQ_A = 1'b1; tick(3); REQ_A = 1'b0;
    wait_idle("withdraw_idle_timeout");
    tick(5);
    chk("withdraw_busy", 32'(BUSY), 32'd0);
    chk("withdraw_ack_a", ack_a_cnt - a0, 0);
    chk("post_rst_ack_b", ack_b_cnt - b0, 1);

    // DW=12 full-scale sample
    DAT_A12 = 12'hFFF; REQ_A12 = 1'b1; exp12.push_back(16'h7FFF);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ICLK);
      if (ACK_A12) begin ok = 1; break; end
    end
    chk("dw12_ack_timeout", 32'(ok), 32'd1);
    REQ_A12 = 1'b0;
    chk("dw12_ncs_at_ack", 32'(nCS12), 32'd0);
    len = 1; bits = '0; sp = SCK12;
    for (int i = 0; i < 40; i++) begin
      @(negedge ICLK);
      if (!nCS12) len++;
      if (SCK12 && !sp) bits = {bits[14:0], SDI12};
      sp = SCK12;
    end
    chk("dw12_frame", 32'(bits), 32'(exp12.pop_front()));
    chk("dw12_ncs_len", len, 34);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_sched.md
# dac_spi_sched

Two-channel scheduler for the serial DAC link. It accepts 8-bit samples from two independent requesters (channel A and channel B) over REQ/ACK handshakes, and arbitrates between them round-robin. It builds each 16-bit DAC command frame and sequences nCS, SCK and SDI itself, with SCK at ICLK/2. It sits between the waveform generators and the DAC pins, replacing free-running serialisation with on-demand, shared access.

## Interface
- DW, 8, sample width; 1..12; left-justified into the 12-bit data field, LSBs zero-filled
- CMD, 3'b111, {BUF, GA, SHDN} bits of every frame
- GAP_CYCLES, 2, ICLK cycles with nCS high after a frame before IDLE; minimum 2
- ICLK  in  1  sole clock; all logic is on the rising edge
- nRST  in  1  asynchronous active-low reset
- REQ_A, REQ_B  in  1  request; held high with data stable until ACK
- DAT_A, DAT_B  in  DW  sample for the channel
- ACK_A, ACK_B  out  1  one-cycle pulse; data has been captured
- nCS  out  1  DAC chip select, active low
- SCK  out  1  serial clock; the DAC samples on the rising edge
- SDI  out  1  serial data, MSB first
- nLDAC  out  1  DAC latch strobe (see Configuration)
- BUSY  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: at a rising edge with any REQ high, select the winner and make these updates:
  - load sreg with {ch, CMD, DAT, zeros}, where ch is 0 for A and 1 for B;
  - set ACK_winner=1 for the next cycle only;
  - set nCS=0 and go to SETUP.
- Arbitration:
  - If only one REQ is high, that channel wins.
  - If both are high, the channel not served last wins.
  - The last-served pointer resets to B, so A wins the first tie.
- SETUP: one cycle with SCK=0 and SDI=sreg[15]. Then go to SHIFT.
- SHIFT: 32 cycles. SCK toggles every cycle, starting with a rise.
  - On each falling transition of SCK, sreg shifts left by one and zero-fills.
  - After the 16th rise and its fall, SCK=0. Go to HOLD.
- HOLD: one cycle with nCS still low. Then set nCS=1 and go to GAP.
- GAP: GAP_CYCLES cycles, then go to IDLE.
- A requester whose REQ stays high after ACK is treated as a new request. It still loses to the other channel if that channel is also pending.
- A REQ that drops before ACK is treated as withdrawn; no frame is sent.
- Reset values: nCS=1, SCK=0, SDI=0, ACK_A=ACK_B=0, nLDAC=1 (or 0 without the macro), BUSY=0, state=IDLE.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The frame is abandoned and not re-sent, and no ACK is reissued.

## Timing
- Capture edge to nCS low: same edge. ACK is high in the first nCS-low cycle.
- nCS stays low for exactly 34 ICLK cycles: SETUP 1 + SHIFT 32 + HOLD 1.
- SDI is stable for at least one ICLK before and after each SCK rise.
- nCS is high for GAP_CYCLES+1 cycles between frames.
- Back-to-back frame period is 35+GAP_CYCLES cycles (37 by default).
- Frame data is captured at the selection edge, so DAT may change once ACK is seen.

## Configuration
- DAC_SCHED_LDAC_EN defined:
  - nLDAC idles high.
  - nLDAC pulses low for the first 2 GAP cycles after every frame.
  - The DAC output updates only on that pulse.
- Not defined: nLDAC is tied to 0 and the DAC updates on the rising edge of nCS. No pulse logic is generated.

## Structure
- Package dac_sched_pkg holds:
  - the state enum;
  - FRAME_W=16;
  - SHIFT_CYCLES=32;
  - the channel-bit constants CH_A=0 and CH_B=1.
- Sub-module dac_spi_shifter contains the 16-bit shift register, SCK toggling and the half-cycle counter. It takes load and go inputs and returns done.
- The arbitration, handshake and state machine stay in dac_spi_sched.

## Test plan
- REQ_A=1 with DAT_A=8'hA5 only → ACK_A pulses once; bits captured on SCK rises are 16'h7A50; nCS is low for 34 cycles.
- REQ_B=1 with DAT_B=8'h3C only → the frame is 16'hF3C0; ACK_A stays 0.
- REQ_A and REQ_B held high together after reset → frames alternate A, B, A; start-to-start spacing is 37 cycles.
- nRST pulsed low at SHIFT cycle 10 → nCS=1 and SCK=0 at once; after release the scheduler is IDLE and a pending REQ starts a fresh frame with a new ACK.
- With DAC_SCHED_LDAC_EN: after a frame, nLDAC is low for exactly 2 cycles starting the cycle after nCS rises. Without it: nLDAC is constantly 0.
- DW=12 with DAT_A=12'hFFF → frame is 16'h7FFF. A REQ_A dropped before ACK produces no frame and no ACK.
